// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared CPU bus source indices and mode constants
// Ports: none (package).
package cpu_bus_pkg;

   localparam int R0  = 0;
   localparam int R1  = 1;
   localparam int R2  = 2;
   localparam int R3  = 3;
   localparam int R4  = 4;
   localparam int R5  = 5;
   localparam int R6  = 6;
   localparam int R7  = 7;
   localparam int R8  = 8;
   localparam int R9  = 9;
   localparam int R10 = 10;
   localparam int R11 = 11;
   localparam int R12 = 12;
   localparam int R13 = 13;
   localparam int R14 = 14;
   localparam int R15 = 15;
   localparam int HI     = 16;
   localparam int LO     = 17;
   localparam int ZHIGH  = 18;
   localparam int ZLOW   = 19;
   localparam int PC     = 20;
   localparam int MDR    = 21;
   localparam int INPORT = 22;
   localparam int CSIGN  = 23;

   localparam int N_BUS_SRC = 24;

   localparam int CONFLICT_PRIORITY = 0;
   localparam int CONFLICT_ZERO     = 1;

   localparam int HOLD_ZERO = 0;
   localparam int HOLD_LAST = 1;

endpackage

// File: rtl/onehot_prio_encoder.sv
// rtl/onehot_prio_encoder.sv - lowest-index priority encoder with any/multi detect
// Ports:
//   req   - request vector (expected one-hot or zero)
//   idx   - index of lowest set bit, 0 when none set
//   any   - at least one bit set
//   multi - two or more bits set
module onehot_prio_encoder #(
   parameter int N = 24
) (
   input  logic [N-1:0]          req,
   output logic [$clog2(N)-1:0]  idx,
   output logic                  any,
   output logic                  multi
);

   localparam int IW = $clog2(N);

   // Scan from the top down so the lowest set bit is written last and wins.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
   end

   assign any = |req;

   // Clearing the lowest set bit leaves something only if a second bit was set.
   assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/shared_bus_mux.sv
// rtl/shared_bus_mux.sv - one-hot CPU bus multiplexer with hold, conflict resolution and error tracking
// Ports:
//   clock, reset_n   - rising-edge clock, asynchronous active-low reset
//   src_data         - packed sources, source i at [i*WIDTH +: WIDTH]
//   src_out          - per-source drive enables
//   err_clr          - synchronous clear of conflict_sticky / conflict_count
//   bus_out          - bus value (registered when OUT_REG=1, else combinational)
//   bus_valid        - some source enabled (registered)
//   bus_src          - encoded selected source, 0 when none or zeroed conflict (registered)
//   conflict         - more than one enable asserted (registered)
//   conflict_sticky  - set by any conflict until err_clr
//   conflict_count   - saturating count of conflict cycles
module shared_bus_mux
   import cpu_bus_pkg::*;
#(
   parameter  int N_SRC         = 24,
   parameter  int WIDTH         = 32,
   parameter  int OUT_REG       = 1,
   parameter  int HOLD_MODE     = 0,
   parameter  int CONFLICT_MODE = 0,
   parameter  int CNT_W         = 8,
   localparam int SRC_W         = $clog2(N_SRC)
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [N_SRC*WIDTH-1:0]  src_data,
   input  logic [N_SRC-1:0]        src_out,
   input  logic                    err_clr,
   output logic [WIDTH-1:0]        bus_out,
   output logic                    bus_valid,
   output logic [SRC_W-1:0]        bus_src,
   output logic                    conflict,
   output logic                    conflict_sticky,
   output logic [CNT_W-1:0]        conflict_count
);

   logic [SRC_W-1:0] sel;
   logic             any;
   logic             multi;

   onehot_prio_encoder #(.N(N_SRC)) u_enc (
      .req   (src_out),
      .idx   (sel),
      .any   (any),
      .multi (multi)
   );

   logic [WIDTH-1:0] src_arr [N_SRC];

   for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
      assign src_arr[g] = src_data[g*WIDTH +: WIDTH];
   end

   logic [WIDTH-1:0] hold_q;
   logic [WIDTH-1:0] d_next;
   logic [SRC_W-1:0] src_next;
   logic             zero_on_conflict;

   assign zero_on_conflict = multi && (CONFLICT_MODE == CONFLICT_ZERO);

   // A zeroed conflict also reports source 0, so the debug tap never names a
   // source that did not actually reach the bus.
   always_comb begin
      d_next   = '0;
      src_next = '0;
      if (!any) begin
         d_next = (HOLD_MODE == HOLD_LAST) ? hold_q : '0;
      end else if (!zero_on_conflict) begin
         d_next   = src_arr[sel];
         src_next = sel;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hold_q <= '0;
      end else if (any) begin
         hold_q <= d_next;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus_valid <= 1'b0;
         bus_src   <= '0;
         conflict  <= 1'b0;
      end else begin
         bus_valid <= any;
         bus_src   <= src_next;
         conflict  <= multi;
      end
   end

   // Clear takes effect first, so a conflict in the clearing cycle is still
   // recorded as the first event of the new window.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         conflict_sticky <= 1'b0;
         conflict_count  <= '0;
      end else if (err_clr) begin
         conflict_sticky <= multi;
         conflict_count  <= multi ? CNT_W'(1) : '0;
      end else if (multi) begin
         conflict_sticky <= 1'b1;
         if (conflict_count != '1) conflict_count <= conflict_count + CNT_W'(1);
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] bus_q;
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) bus_q <= '0;
         else          bus_q <= d_next;
      end
      assign bus_out = bus_q;
   end else begin : g_out_comb
      assign bus_out = d_next;
   end

endmodule

// File: tb/tb_shared_bus_mux.sv
// tb/tb_shared_bus_mux.sv - self-checking bench for shared_bus_mux across three configurations
// Ports: none (top-level bench).
module tb_shared_bus_mux;
   import cpu_bus_pkg::*;

   logic              clock = 1'b0;
   logic              reset_n;
   logic [24*32-1:0]  src_data;
   logic [23:0]       src_out;
   logic              err_clr;

   logic [31:0] bus_a   [3];
   logic        valid_a [3];
   logic [4:0]  src_a   [3];
   logic        conf_a  [3];
   logic        stk_a   [3];
   logic [7:0]  cnt_a   [3];
   logic [7:0]  cnt0, cnt2;
   logic [3:0]  cnt1;

   assign cnt_a[0] = cnt0;
   assign cnt_a[1] = {4'b0, cnt1};
   assign cnt_a[2] = cnt2;

   always #5 clock = ~clock;

   // u0: defaults; u1: hold-last, zero-on-conflict, 4-bit counter; u2: combinational bus
   shared_bus_mux u0 (
      .clock(clock), .reset_n(reset_n), .src_data(src_data), .src_out(src_out),
      .err_clr(err_clr), .bus_out(bus_a[0]), .bus_valid(valid_a[0]), .bus_src(src_a[0]),
      .conflict(conf_a[0]), .conflict_sticky(stk_a[0]), .conflict_count(cnt0));

   shared_bus_mux #(.HOLD_MODE(HOLD_LAST), .CONFLICT_MODE(CONFLICT_ZERO), .CNT_W(4)) u1 (
      .clock(clock), .reset_n(reset_n), .src_data(src_data), .src_out(src_out),
      .err_clr(err_clr), .bus_out(bus_a[1]), .bus_valid(valid_a[1]), .bus_src(src_a[1]),
      .conflict(conf_a[1]), .conflict_sticky(stk_a[1]), .conflict_count(cnt1));

   shared_bus_mux #(.OUT_REG(0)) u2 (
      .clock(clock), .reset_n(reset_n), .src_data(src_data), .src_out(src_out),
      .err_clr(err_clr), .bus_out(bus_a[2]), .bus_valid(valid_a[2]), .bus_src(src_a[2]),
      .conflict(conf_a[2]), .conflict_sticky(stk_a[2]), .conflict_count(cnt2));

   typedef struct {
      logic [31:0] bus;
      logic        valid;
      logic [4:0]  src;
      logic        conf;
      logic        stk;
      logic [7:0]  cnt;
   } exp_t;

   typedef struct {
      logic [23:0] so;
      logic [31:0] bus;
      logic        valid;
      logic [4:0]  src;
      logic        conf;
   } vec_t;

   int checks = 0;
   int errors = 0;

   logic [31:0] data_arr [24];
   exp_t        sb_q [$];

   logic [31:0] m_hold [3];
   logic        m_stk  [3];
   int          m_cnt  [3];
   int          cnt_max   [3] = '{255, 15, 255};
   int          hold_last [3] = '{0, 1, 0};
   int          conf_zero [3] = '{0, 1, 0};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_hold[k] = '0;
         m_stk[k]  = 1'b0;
         m_cnt[k]  = 0;
      end
   endtask

   // Reference behaviour for one cycle of configuration k; dn is the bus value
   // chosen this cycle before the edge.
   task automatic model(input int k, input logic [23:0] so, input logic clr,
                        output exp_t e, output logic [31:0] dn);
      int sel = -1;
      int n   = 0;
      for (int i = 0; i < 24; i++) begin
         if (so[i]) begin
            n++;
            if (sel < 0) sel = i;
         end
      end
      if (n == 0)                         dn = hold_last[k] ? m_hold[k] : 32'h0;
      else if (n > 1 && conf_zero[k] != 0) dn = 32'h0;
      else                                 dn = data_arr[sel];
      e.bus   = dn;
      e.valid = (n > 0);
      e.conf  = (n > 1);
      e.src   = (n == 0 || (n > 1 && conf_zero[k] != 0)) ? 5'd0 : 5'(sel);
      if (n > 0) m_hold[k] = dn;
      if (clr) begin
         m_stk[k] = 1'b0;
         m_cnt[k] = 0;
      end
      if (n > 1) begin
         m_stk[k] = 1'b1;
         if (m_cnt[k] < cnt_max[k]) m_cnt[k]++;
      end
      e.stk = m_stk[k];
      e.cnt = 8'(m_cnt[k]);
   endtask

   // Drives one cycle, checks u2's combinational bus before the edge, then
   // pops the scoreboard and checks every registered output after it.
   task automatic step(input logic [23:0] so, input logic clr);
      exp_t        e;
      logic [31:0] dn;
      logic [31:0] comb2 = '0;
      src_out = so;
      err_clr = clr;
      for (int i = 0; i < 24; i++) src_data[i*32 +: 32] = data_arr[i];
      for (int k = 0; k < 3; k++) begin
         model(k, so, clr, e, dn);
         sb_q.push_back(e);
         if (k == 2) comb2 = dn;
      end
      @(negedge clock);
      chk("u2_comb_bus", bus_a[2], comb2);
      @(posedge clock);
      #1;
      for (int k = 0; k < 3; k++) begin
         e = sb_q.pop_front();
         if (k < 2) chk($sformatf("u%0d_bus", k), bus_a[k], e.bus);
         chk($sformatf("u%0d_valid", k),  valid_a[k], e.valid);
         chk($sformatf("u%0d_src", k),    src_a[k],   e.src);
         chk($sformatf("u%0d_conflict", k), conf_a[k], e.conf);
         chk($sformatf("u%0d_sticky", k), stk_a[k],   e.stk);
         chk($sformatf("u%0d_count", k),  cnt_a[k],   e.cnt);
      end
      err_clr = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s_u%0d_bus", tag, k),    bus_a[k],   0);
         chk($sformatf("%s_u%0d_valid", tag, k),  valid_a[k], 0);
         chk($sformatf("%s_u%0d_src", tag, k),    src_a[k],   0);
         chk($sformatf("%s_u%0d_conf", tag, k),   conf_a[k],  0);
         chk($sformatf("%s_u%0d_sticky", tag, k), stk_a[k],   0);
         chk($sformatf("%s_u%0d_count", tag, k),  cnt_a[k],   0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [6];
      logic [23:0] conf_pair;

      reset_n  = 1'b0;
      src_out  = '0;
      err_clr  = 1'b0;
      src_data = '0;
      for (int i = 0; i < 24; i++) data_arr[i] = 32'hA000_0000 + 32'(i);
      model_reset();

      repeat (3) @(posedge clock);
      #1;
      chk_all_zero("reset");
      reset_n = 1'b1;

      // One-hot sweep, one new selection every cycle.
      for (int i = 0; i < 24; i++) step(24'd1 << i, 1'b0);

      data_arr[PC]   = 32'h0000_1234;
      data_arr[R3]   = 32'h0000_0003;
      data_arr[MDR]  = 32'hDEAD_BEEF;
      data_arr[ZLOW] = 32'hCAFE_0001;
      conf_pair      = (24'd1 << R3) | (24'd1 << MDR);

      // Bus hold versus bus zero after PC drops off.
      step(24'd1 << PC, 1'b0);
      step(24'd0, 1'b0);
      chk("hold_u0_bus_zero", bus_a[0], 32'h0);
      chk("hold_u1_bus_kept", bus_a[1], 32'h0000_1234);
      chk("hold_u1_valid", valid_a[1], 1'b0);

      // Expected values for the default configuration (u0).
      tbl[0] = '{24'd1 << PC,                      32'h0000_1234, 1'b1, 5'd20, 1'b0};
      tbl[1] = '{24'd0,                            32'h0000_0000, 1'b0, 5'd0,  1'b0};
      tbl[2] = '{conf_pair,                        32'h0000_0003, 1'b1, 5'd3,  1'b1};
      tbl[3] = '{24'd1 << ZLOW,                    32'hCAFE_0001, 1'b1, 5'd19, 1'b0};
      tbl[4] = '{(24'd1 << HI) | (24'd1 << LO),    32'hA000_0010, 1'b1, 5'd16, 1'b1};
      tbl[5] = '{24'd1 << CSIGN,                   32'hA000_0017, 1'b1, 5'd23, 1'b0};
      for (int v = 0; v < 6; v++) begin
         step(tbl[v].so, 1'b0);
         chk($sformatf("tbl%0d_bus", v),   bus_a[0],   tbl[v].bus);
         chk($sformatf("tbl%0d_valid", v), valid_a[0], tbl[v].valid);
         chk($sformatf("tbl%0d_src", v),   src_a[0],   tbl[v].src);
         chk($sformatf("tbl%0d_conf", v),  conf_a[0],  tbl[v].conf);
      end
      chk("conf_zero_u1_sticky", stk_a[1], 1'b1);
      chk("conf_zero_u1_count", cnt_a[1], 8'd2);

      // Saturation: 20 more conflict cycles.
      for (int c = 0; c < 20; c++) step(conf_pair, 1'b0);
      chk("sat_u1_count", cnt_a[1], 8'd15);
      chk("sat_u0_count", cnt_a[0], 8'd22);
      step(conf_pair, 1'b1);
      chk("clr_multi_u1_count", cnt_a[1], 8'd1);
      chk("clr_multi_u1_sticky", stk_a[1], 1'b1);
      step(24'd0, 1'b1);
      chk("clr_only_u1_count", cnt_a[1], 8'd0);
      chk("clr_only_u0_sticky", stk_a[0], 1'b0);

      // Combinational bus: value same cycle, flags one cycle later.
      src_out = 24'd1 << ZLOW;
      #1;
      chk("comb_u2_bus_same_cycle", bus_a[2], 32'hCAFE_0001);
      chk("comb_u2_valid_lags", valid_a[2], 1'b0);
      step(24'd1 << ZLOW, 1'b0);
      chk("comb_u2_src_next", src_a[2], 5'd19);

      // Asynchronous reset in the middle of a transfer.
      data_arr[LO] = 32'h5555_AAAA;
      step(24'd1 << LO, 1'b0);
      chk("pre_reset_u0_bus", bus_a[0], 32'h5555_AAAA);
      #2;
      src_out = '0;
      reset_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      step(24'd0, 1'b0);
      chk("post_reset_u1_hold_cleared", bus_a[1], 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
